// File: rtl/cvxif_copro_pkg.sv
// -----------------------------------------------------------------------------
// cvxif_copro_pkg
// Shared types for the CV-X-IF example coprocessor execution stage.
//   copro_opcode_e    : decoded opcode encoding (value 7 is reserved)
//   copro_lat_class_e : latency class of an opcode (none / single / multi)
//   copro_state_e     : execution FSM states
//   copro_result_t    : result record {hartid, id, data, rd, we} at the
//                       default widths; also the default FIFO entry type
//   lat_class()       : maps a raw 3-bit opcode to its latency class
// -----------------------------------------------------------------------------
package cvxif_copro_pkg;

  localparam int unsigned CoproXlen        = 32;
  localparam int unsigned CoproIdWidth     = 4;
  localparam int unsigned CoproHartidWidth = 1;

  typedef enum logic [2:0] {
    OPC_ILLEGAL    = 3'd0,
    OPC_NOP        = 3'd1,
    OPC_ADD        = 3'd2,
    OPC_DOUBLE_RS1 = 3'd3,
    OPC_DOUBLE_RS2 = 3'd4,
    OPC_ADD_MULTI  = 3'd5,
    OPC_ADD_RS3    = 3'd6
  } copro_opcode_e;

  typedef enum logic [1:0] {
    LAT_NONE   = 2'd0,  // consumed, no result
    LAT_SINGLE = 2'd1,  // result pushed on the transfer edge
    LAT_MULTI  = 2'd2   // result pushed after funct2+1 cycles
  } copro_lat_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } copro_state_e;

  typedef struct packed {
    logic [CoproHartidWidth-1:0] hartid;
    logic [CoproIdWidth-1:0]     id;
    logic [CoproXlen-1:0]        data;
    logic [4:0]                  rd;
    logic                        we;
  } copro_result_t;

  // Raw opcode in, so the reserved encoding falls into the default arm.
  function automatic copro_lat_class_e lat_class(input logic [2:0] opcode);
    case (opcode)
      OPC_NOP, OPC_ADD, OPC_DOUBLE_RS1,
      OPC_DOUBLE_RS2, OPC_ADD_RS3:       lat_class = LAT_SINGLE;
      OPC_ADD_MULTI:                     lat_class = LAT_MULTI;
      default:                           lat_class = LAT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/copro_result_fifo.sv
// -----------------------------------------------------------------------------
// copro_result_fifo
// In-order synchronous FIFO of result records. The head entry is presented
// combinationally; an empty FIFO presents all-zero data.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write data_i at the clock edge (ignored when full)
//   data_i       : entry to write
//   pop_i        : drop the head entry at the clock edge (ignored when empty)
//   data_o       : head entry
//   full_o       : count == Depth
//   empty_o      : count == 0
//   count_o      : number of stored entries
// -----------------------------------------------------------------------------
module copro_result_fifo
  import cvxif_copro_pkg::*;
#(
  parameter type         entry_t = copro_result_t,
  parameter int unsigned Depth   = 4   // power of 2, >= 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  entry_t                 data_i,
  input  logic                   pop_i,
  output entry_t                 data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
  localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(Depth);

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CountFull);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  // NOTE: sequential state is written with non-blocking '<=' so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountOne;
        2'b01:   r_count <= r_count - CountOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is carried by r_count alone, and the
  // output is masked while empty so stale entries never become visible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  assign data_o = empty_o ? entry_t'('0) : r_mem[r_rptr];

endmodule

// File: rtl/copro_exec_stage.sv
// -----------------------------------------------------------------------------
// copro_exec_stage
// Execution stage of the CV-X-IF example coprocessor. Computes the result of
// each accepted instruction and queues it in an in-order result FIFO.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   valid_i / ready_o : instruction handshake (transfer on valid_i && ready_o)
//   opcode_i          : decoded opcode (copro_opcode_e encoding)
//   hartid_i, id_i    : instruction tags, returned with the result
//   rd_i              : destination register
//   funct2_i          : extra latency for ADD_MULTI (0..3)
//   registers_i       : source operands, rs1 in the LSBs
//   result_valid_o / result_ready_i : result handshake
//   result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o :
//                       head-of-FIFO result fields
// -----------------------------------------------------------------------------
module copro_exec_stage
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NrRgprPorts = 3,   // 2 or 3
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned HartidWidth = 1,
  parameter int unsigned ResultDepth = 4    // power of 2, >= 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [2:0]                    opcode_i,
  input  logic [HartidWidth-1:0]        hartid_i,
  input  logic [IdWidth-1:0]            id_i,
  input  logic [4:0]                    rd_i,
  input  logic [1:0]                    funct2_i,
  input  logic [NrRgprPorts*XLEN-1:0]   registers_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [HartidWidth-1:0]        result_hartid_o,
  output logic [IdWidth-1:0]            result_id_o,
  output logic [XLEN-1:0]               result_data_o,
  output logic [4:0]                    result_rd_o,
  output logic                          result_we_o
);

  // Same layout as copro_result_t, sized by this instance's parameters.
  typedef struct packed {
    logic [HartidWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [XLEN-1:0]        data;
    logic [4:0]             rd;
    logic                   we;
  } result_t;

  // ---------------------------------------------------------------------------
  // Operand extraction; rs3 reads as zero when only two ports exist, which
  // makes ADD_RS3 degrade to rs1+rs2.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_rs3;

  assign w_rs1 = registers_i[XLEN-1:0];
  assign w_rs2 = registers_i[2*XLEN-1:XLEN];

  generate
    if (NrRgprPorts >= 3) begin : g_rs3
      assign w_rs3 = registers_i[3*XLEN-1:2*XLEN];
    end else begin : g_no_rs3
      assign w_rs3 = '0;
    end
  endgenerate

  // Single-cycle ALU; all sums wrap modulo 2^XLEN.
  function automatic logic [XLEN-1:0] alu(input logic [2:0]      op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b,
                                          input logic [XLEN-1:0] c);
    case (op)
      OPC_ADD, OPC_ADD_MULTI: alu = a + b;
      OPC_DOUBLE_RS1:         alu = a + a;
      OPC_DOUBLE_RS2:         alu = b + b;
      OPC_ADD_RS3:            alu = a + b + c;
      default:                alu = '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  copro_state_e           r_state;
  logic [1:0]             r_cnt;
  logic [XLEN-1:0]        r_mc_rs1;
  logic [XLEN-1:0]        r_mc_rs2;
  logic [HartidWidth-1:0] r_mc_hartid;
  logic [IdWidth-1:0]     r_mc_id;
  logic [4:0]             r_mc_rd;

  copro_lat_class_e w_class;
  logic             w_transfer;
  logic             w_mc_done;
  logic             w_push;
  logic             w_pop;
  result_t          w_push_data;
  result_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic [$clog2(ResultDepth):0] w_unused_count;

  assign w_class    = lat_class(opcode_i);
  // ready_o depends only on registered state, so a same-cycle pop cannot
  // raise it and there is no path from result_ready_i.
  assign ready_o    = (r_state == ST_IDLE) && !w_full;
  assign w_transfer = valid_i && ready_o;
  assign w_mc_done  = (r_state == ST_EXEC) && (r_cnt == 2'd0);

  // EXEC holds ready_o low, so the two push sources never coincide.
  assign w_push = (w_transfer && (w_class == LAT_SINGLE)) || w_mc_done;
  assign w_pop  = result_valid_o && result_ready_i;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch can be inferred.
  always_comb begin
    w_push_data = '0;
    if (r_state == ST_EXEC) begin
      w_push_data.hartid = r_mc_hartid;
      w_push_data.id     = r_mc_id;
      w_push_data.data   = alu(OPC_ADD_MULTI, r_mc_rs1, r_mc_rs2, '0);
      w_push_data.rd     = r_mc_rd;
      w_push_data.we     = 1'b1;
    end else begin
      w_push_data.hartid = hartid_i;
      w_push_data.id     = id_i;
      w_push_data.data   = alu(opcode_i, w_rs1, w_rs2, w_rs3);
      w_push_data.rd     = rd_i;
      w_push_data.we     = (opcode_i != OPC_NOP);
    end
  end

  // ADD_MULTI: latch the instruction, count funct2 down to zero, push on the
  // cycle the counter reads zero -> push edge is funct2+1 edges after transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mc_rs1    <= '0;
      r_mc_rs2    <= '0;
      r_mc_hartid <= '0;
      r_mc_id     <= '0;
      r_mc_rd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_transfer && (w_class == LAT_MULTI)) begin
            r_mc_rs1    <= w_rs1;
            r_mc_rs2    <= w_rs2;
            r_mc_hartid <= hartid_i;
            r_mc_id     <= id_i;
            r_mc_rd     <= rd_i;
            r_cnt       <= funct2_i;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == 2'd0) r_state <= ST_IDLE;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  copro_result_fifo #(
    .entry_t (result_t),
    .Depth   (ResultDepth)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_unused_count)
  );

  assign result_valid_o  = !w_empty;
  assign result_hartid_o = w_head.hartid;
  assign result_id_o     = w_head.id;
  assign result_data_o   = w_head.data;
  assign result_rd_o     = w_head.rd;
  assign result_we_o     = w_head.we;

endmodule

// File: tb/tb_copro_exec_stage.sv
module tb_copro_exec_stage;
  import cvxif_copro_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  opcode = '0;
  logic [0:0]  hartid = '0;
  logic [3:0]  id = '0;
  logic [4:0]  rd = '0;
  logic [1:0]  funct2 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
  logic        result_ready = 1'b1;

  logic [95:0] regs3;
  logic [63:0] regs2;
  assign regs3 = {rs3, rs2, rs1};
  assign regs2 = {rs2, rs1};

  logic        ready, rvalid, rwe;
  logic [0:0]  rhartid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [4:0]  rrd;

  logic        ready2, rvalid2, rwe2;
  logic [0:0]  rhartid2;
  logic [3:0]  rid2;
  logic [31:0] rdata2;
  logic [4:0]  rrd2;

  always #5 clk = ~clk;

  copro_exec_stage dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .opcode_i(opcode), .hartid_i(hartid), .id_i(id), .rd_i(rd),
    .funct2_i(funct2), .registers_i(regs3),
    .result_valid_o(rvalid), .result_ready_i(result_ready),
    .result_hartid_o(rhartid), .result_id_o(rid), .result_data_o(rdata),
    .result_rd_o(rrd), .result_we_o(rwe)
  );

  copro_exec_stage #(.NrRgprPorts(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready2),
    .opcode_i(opcode), .hartid_i(hartid), .id_i(id), .rd_i(rd),
    .funct2_i(funct2), .registers_i(regs2),
    .result_valid_o(rvalid2), .result_ready_i(result_ready),
    .result_hartid_o(rhartid2), .result_id_o(rid2), .result_data_o(rdata2),
    .result_rd_o(rrd2), .result_we_o(rwe2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: lat = negedges after the drive edge at which the result
  // first appears (0 = no result ever).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]  op;
    logic [1:0]  f2;
    logic [31:0] a, b, c;
    int          lat;
    logic [31:0] d3, d2;
    logic        we;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int i, input vec_t v);
    int got;
    logic [31:0] gd, gd2;
    logic        gwe;
    logic [3:0]  gid;
    logic [4:0]  grd;
    got = 0; gd = '0; gd2 = '0; gwe = 1'b0; gid = '0; grd = '0;
    @(negedge clk);
    opcode = v.op; funct2 = v.f2; rs1 = v.a; rs2 = v.b; rs3 = v.c;
    id = 4'(i); rd = 5'(i + 3); valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      if (rvalid && got == 0) begin
        got = k; gd = rdata; gd2 = rdata2; gwe = rwe; gid = rid; grd = rrd;
      end
    end
    check($sformatf("vec%0d_latency", i), 32'(got), 32'(v.lat));
    if (v.lat != 0 && got != 0) begin
      check($sformatf("vec%0d_data", i), gd, v.d3);
      check($sformatf("vec%0d_data_2port", i), gd2, v.d2);
      check($sformatf("vec%0d_we", i), 32'(gwe), 32'(v.we));
      check($sformatf("vec%0d_id", i), 32'(gid), 32'(i));
      check($sformatf("vec%0d_rd", i), 32'(grd), 32'(i + 3));
    end
    check($sformatf("vec%0d_empty_after", i), 32'(rvalid), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of results in acceptance order, plus a countdown
  // for the one ADD_MULTI that may be in flight.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [0:0]  hartid;
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } res_t;

  res_t mq[$];
  int   busy = 0;
  res_t pending;

  function automatic logic [31:0] model_value(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
    longint unsigned s;
    case (op)
      OPC_ADD, OPC_ADD_MULTI: s = longint'(a) + longint'(b);
      OPC_DOUBLE_RS1:         s = 2 * longint'(a);
      OPC_DOUBLE_RS2:         s = 2 * longint'(b);
      OPC_ADD_RS3:            s = longint'(a) + longint'(b) + longint'(c);
      default:                s = 0;
    endcase
    return 32'(s % 64'h1_0000_0000);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OPC_ADD,        2'd0, 32'h0000_0005, 32'h0000_0003, 32'h0,   1, 32'h8,         32'h8,         1'b1};
    vecs[1] = '{OPC_ADD_RS3,    2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4,   1, 32'h4,         32'h0,         1'b1};
    vecs[2] = '{OPC_DOUBLE_RS1, 2'd0, 32'h8000_0001, 32'h0000_0007, 32'h9,   1, 32'h2,         32'h2,         1'b1};
    vecs[3] = '{OPC_DOUBLE_RS2, 2'd0, 32'h0000_0001, 32'h1234_5678, 32'h0,   1, 32'h2468_ACF0, 32'h2468_ACF0, 1'b1};
    vecs[4] = '{OPC_NOP,        2'd0, 32'h0000_0011, 32'h0000_0022, 32'h33,  1, 32'h0,         32'h0,         1'b0};
    vecs[5] = '{OPC_ADD_MULTI,  2'd0, 32'd10,        32'd20,        32'h0,   2, 32'd30,        32'd30,        1'b1};
    vecs[6] = '{OPC_ADD_MULTI,  2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0,   4, 32'h1,         32'h1,         1'b1};
    vecs[7] = '{OPC_ILLEGAL,    2'd0, 32'h0000_0001, 32'h0000_0002, 32'h3,   0, 32'h0,         32'h0,         1'b0};
    vecs[8] = '{3'd7,           2'd1, 32'h0000_0001, 32'h0000_0002, 32'h3,   0, 32'h0,         32'h0,         1'b0};

    // ---- reset values ----
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready), 1);
    check("reset_valid", 32'(rvalid), 0);
    check("reset_data", rdata, 0);
    check("reset_id", 32'(rid), 0);
    check("reset_rd", 32'(rrd), 0);
    check("reset_we", 32'(rwe), 0);
    check("reset_hartid", 32'(rhartid), 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven single transactions ----
    result_ready = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // ---- ADD_MULTI funct2=3 with an instruction presented during EXEC ----
    begin
      int stray;
      @(negedge clk);
      opcode = OPC_ADD_MULTI; funct2 = 2'd3; rs1 = 32'd10; rs2 = 32'd20;
      id = 4'd5; rd = 5'd9; valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) begin opcode = OPC_ADD; id = 4'd9; end
        check("multi_ready_low", 32'(ready), 0);
        check("multi_valid_low", 32'(rvalid), 0);
      end
      valid = 1'b0;
      @(negedge clk);
      check("multi_ready_back", 32'(ready), 1);
      check("multi_valid", 32'(rvalid), 1);
      check("multi_data", rdata, 32'd30);
      check("multi_id", 32'(rid), 5);
      stray = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (rvalid) stray++;
      end
      check("multi_no_stray_result", 32'(stray), 0);
    end

    // ---- backpressure: five back-to-back ADDs into a depth-4 FIFO ----
    begin
      int took4;
      logic [3:0]  pid[$];
      logic [31:0] pdat[$];
      @(negedge clk);
      result_ready = 1'b0; opcode = OPC_ADD; funct2 = 2'd0; rs2 = 32'd100; valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        id = 4'(i); rs1 = 32'(i);
        check("bp_ready_before_full", 32'(ready), 1);
        @(negedge clk);
      end
      id = 4'd4; rs1 = 32'd4;
      check("bp_ready_when_full", 32'(ready), 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("bp_stall_ready", 32'(ready), 0);
        check("bp_stall_id", 32'(rid), 0);
        check("bp_stall_data", rdata, 32'd100);
      end
      result_ready = 1'b1;
      #1;
      check("bp_pop_no_comb_ready", 32'(ready), 0);
      took4 = 0;
      for (int k = 0; k < 16; k++) begin
        if (rvalid) begin pid.push_back(rid); pdat.push_back(rdata); end
        if (valid && ready) took4 = 1;
        @(negedge clk);
        if (took4 != 0) valid = 1'b0;
      end
      valid = 1'b0;
      check("bp_id4_accepted", 32'(took4), 1);
      check("bp_drain_count", 32'(pid.size()), 5);
      for (int i = 0; i < 5 && i < pid.size(); i++) begin
        check($sformatf("bp_order_id%0d", i), 32'(pid[i]), 32'(i));
        check($sformatf("bp_order_data%0d", i), pdat[i], 32'(100 + i));
      end
    end

    // ---- NOP then ILLEGAL ----
    begin
      res_t seen[$];
      res_t r;
      @(negedge clk);
      opcode = OPC_NOP; id = 4'd1; rd = 5'd4; rs1 = 32'h55; rs2 = 32'h66; valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        if (k == 0) begin opcode = OPC_ILLEGAL; id = 4'd2; end
        if (k == 1) valid = 1'b0;
        if (rvalid) begin
          r.hartid = rhartid; r.id = rid; r.data = rdata; r.rd = rrd; r.we = rwe;
          seen.push_back(r);
        end
      end
      check("nop_ill_result_count", 32'(seen.size()), 1);
      if (seen.size() > 0) begin
        check("nop_id", 32'(seen[0].id), 1);
        check("nop_we", 32'(seen[0].we), 0);
        check("nop_data", seen[0].data, 0);
      end
    end

    // ---- reset during EXEC with two results queued ----
    begin
      int stale;
      @(negedge clk);
      result_ready = 1'b0; opcode = OPC_ADD; id = 4'd1; rs1 = 32'd1; rs2 = 32'd1; valid = 1'b1;
      @(negedge clk);
      id = 4'd2;
      @(negedge clk);
      opcode = OPC_ADD_MULTI; funct2 = 2'd3; id = 4'd3;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      check("rst_pre_valid", 32'(rvalid), 1);
      check("rst_pre_ready", 32'(ready), 0);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(rvalid), 0);
      check("rst_async_ready", 32'(ready), 1);
      check("rst_async_id", 32'(rid), 0);
      check("rst_async_data", rdata, 0);
      @(negedge clk);
      rst = 1'b0; result_ready = 1'b1;
      stale = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (rvalid) stale++;
      end
      check("rst_no_stale_result", 32'(stale), 0);
    end

    // ---- randomized traffic against the model ----
    mq.delete();
    busy = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic exp_ready;
      res_t r;
      @(negedge clk);
      exp_ready = (busy == 0) && (mq.size() < 4);
      check("rnd_ready", 32'(ready), 32'(exp_ready));
      check("rnd_valid", 32'(rvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("rnd_data", rdata, mq[0].data);
        check("rnd_id", 32'(rid), 32'(mq[0].id));
        check("rnd_rd", 32'(rrd), 32'(mq[0].rd));
        check("rnd_we", 32'(rwe), 32'(mq[0].we));
        check("rnd_hartid", 32'(rhartid), 32'(mq[0].hartid));
      end
      valid  = ($urandom_range(0, 3) != 0);
      opcode = 3'($urandom_range(0, 7));
      funct2 = 2'($urandom_range(0, 3));
      id     = 4'($urandom);
      rd     = 5'($urandom);
      hartid = 1'($urandom);
      rs1    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rs2    = $urandom;
      rs3    = $urandom;
      result_ready = ($urandom_range(0, 2) != 0);

      // what the next clock edge does
      if (mq.size() != 0 && result_ready) void'(mq.pop_front());
      if (busy > 0) begin
        busy--;
        if (busy == 0) mq.push_back(pending);
      end
      if (valid && exp_ready) begin
        r.hartid = hartid; r.id = id; r.rd = rd;
        r.data = model_value(opcode, rs1, rs2, rs3);
        r.we = (opcode != OPC_NOP);
        case (opcode)
          OPC_NOP, OPC_ADD, OPC_DOUBLE_RS1, OPC_DOUBLE_RS2, OPC_ADD_RS3: mq.push_back(r);
          OPC_ADD_MULTI: begin pending = r; busy = int'(funct2) + 1; end
          default: ;
        endcase
      end
    end
    @(negedge clk);
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
